// File: rtl/mem_arbiter_rr.sv
// Arbitrates N cache front-ends onto one tagged memory port and routes each
// returned load tag back to the requester that issued it.
module mem_arbiter_rr #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned RR_MODE   = 1,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_in,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_in,
    input  logic [NUM_REQ*2-1:0]      req_command_in,
    output logic [NUM_REQ*TAG_W-1:0]  req_response_out,
    output logic [NUM_REQ*TAG_W-1:0]  req_tag_out,
    output logic [DATA_W-1:0]         req_data_out,
    output logic [NUM_REQ-1:0]        req_busy_out,
    output logic [ADDR_W-1:0]         mem_addr_out,
    output logic [DATA_W-1:0]         mem_data_out,
    output logic [1:0]                mem_command_out,
    input  logic [TAG_W-1:0]          mem_response_in,
    input  logic [TAG_W-1:0]          mem_tag_in,
    input  logic [DATA_W-1:0]         mem_data_in,
    output logic                      orphan_err_out
);

    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W  = $clog2(MAX_OUTST + 1);
    localparam int unsigned N_TAGS = 1 << TAG_W;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic [CNT_W-1:0]  cnt_q [NUM_REQ];
    logic [ID_W-1:0]   owner_q [N_TAGS];
    logic [N_TAGS-1:0] owner_vld_q;
    logic              lock_vld_q;
    logic [ID_W-1:0]   lock_id_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic              orphan_q;

    logic [1:0]        cmd   [NUM_REQ];
    logic [ADDR_W-1:0] addr  [NUM_REQ];
    logic [DATA_W-1:0] wdata [NUM_REQ];
    logic [NUM_REQ-1:0] busy;
    logic [NUM_REQ-1:0] elig;
    logic              gnt_vld;
    logic [ID_W-1:0]   gnt_id;
    logic [1:0]        gnt_cmd;
    logic              accept;
    logic              load_acc;
    logic              cpl;
    logic              cpl_hit;
    logic [ID_W-1:0]   cpl_owner;
    logic [ID_W-1:0]   rr_next;
    int unsigned       idx;

    // Per-requester unpacking, eligibility and busy (busy from registered count only)
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cmd[i]   = req_command_in[i*2 +: 2];
            addr[i]  = req_addr_in[i*ADDR_W +: ADDR_W];
            wdata[i] = req_data_in[i*DATA_W +: DATA_W];
            busy[i]  = (cnt_q[i] == CNT_W'(MAX_OUTST));
            elig[i]  = (cmd[i] != BUS_NONE) && !((cmd[i] == BUS_LOAD) && busy[i]);
        end
    end

    assign req_busy_out = busy;

    // Grant selection: a held (rejected) grant wins while its requester still asks
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        if (lock_vld_q && elig[lock_id_q]) begin
            gnt_vld = 1'b1;
            gnt_id  = lock_id_q;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx = (RR_MODE != 0) ? 32'(rr_ptr_q) + k : k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!gnt_vld && elig[ID_W'(idx)]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = ID_W'(idx);
                end
            end
        end
    end

    assign gnt_cmd   = cmd[gnt_id];
    assign accept    = gnt_vld && (mem_response_in != '0);
    assign load_acc  = accept && (gnt_cmd == BUS_LOAD);
    assign cpl       = (mem_tag_in != '0);
    assign cpl_hit   = cpl && owner_vld_q[mem_tag_in];
    assign cpl_owner = owner_q[mem_tag_in];
    assign rr_next   = (32'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + ID_W'(1);

    // Memory-side and requester-side muxing; everything reads idle during reset
    always_comb begin
        mem_command_out  = BUS_NONE;
        mem_addr_out     = '0;
        mem_data_out     = '0;
        req_response_out = '0;
        req_tag_out      = '0;
        req_data_out     = reset_n ? mem_data_in : '0;
        if (reset_n && gnt_vld) begin
            mem_command_out = gnt_cmd;
            mem_addr_out    = addr[gnt_id];
            if (gnt_cmd == BUS_STORE) mem_data_out = wdata[gnt_id];
            req_response_out[32'(gnt_id)*TAG_W +: TAG_W] = mem_response_in;
        end
        if (reset_n && cpl_hit) begin
            req_tag_out[32'(cpl_owner)*TAG_W +: TAG_W] = mem_tag_in;
        end
    end

    assign orphan_err_out = orphan_q;

    // Tag ownership table payload; only meaningful where owner_vld_q is set
    always_ff @(posedge clock) begin
        if (load_acc) owner_q[mem_response_in] <= gnt_id;
    end

    // Control state: valid bits, counts, grant lock, round-robin pointer, orphan flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner_vld_q <= '0;
            lock_vld_q  <= 1'b0;
            lock_id_q   <= '0;
            rr_ptr_q    <= '0;
            orphan_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            if (cpl && !owner_vld_q[mem_tag_in]) orphan_q <= 1'b1;
            // Clear before set so a same-cycle reissue of the returning tag stays valid
            if (cpl_hit)  owner_vld_q[mem_tag_in]      <= 1'b0;
            if (load_acc) owner_vld_q[mem_response_in] <= 1'b1;

            if (accept) begin
                lock_vld_q <= 1'b0;
                rr_ptr_q   <= rr_next;
            end else if (gnt_vld) begin
                lock_vld_q <= 1'b1;
                lock_id_q  <= gnt_id;
            end else begin
                lock_vld_q <= 1'b0;
            end

            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if ((load_acc && gnt_id == ID_W'(i)) && !(cpl_hit && cpl_owner == ID_W'(i)))
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                else if (!(load_acc && gnt_id == ID_W'(i)) && (cpl_hit && cpl_owner == ID_W'(i)))
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
        end
    end

endmodule
